// File: rtl/dmem_sized_ctrl_pkg.sv
// Shared types for the sized data memory controller.
// Holds the access size encoding and the controller FSM state encoding.
package dmem_sized_ctrl_pkg;

   // Access size; the reserved encoding behaves as a word access.
   typedef enum logic [1:0] {
      SizeB    = 2'b00,
      SizeH    = 2'b01,
      SizeW    = 2'b10,
      SizeRsvd = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StWait = 2'b01,
      StResp = 2'b10
   } dmem_state_e;

endpackage

// File: rtl/dmem_sized_ctrl_lane_align.sv
// Combinational byte-lane steering for the sized data memory.
// Ports:
//   size        access size
//   addr_lo     byte address bits [1:0]
//   wdata       right-justified store data
//   rword       full 32-bit word read from the array
//   is_unsigned 1 = zero-extend loads, 0 = sign-extend
//   be          store byte-lane enables
//   wdata_sh    store data moved into its byte lanes
//   rdata_ext   load data shifted down and extended
// Misaligned low address bits are dropped here (half uses addr[1], word uses lane 0);
// when misaligned accesses trap, the controller suppresses their effects instead.
module dmem_sized_ctrl_lane_align
   import dmem_sized_ctrl_pkg::*;
(
   input  mem_size_e   size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   input  logic        is_unsigned,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext
);

   logic [1:0]  lane;
   logic [31:0] shifted;

   always_comb begin
      lane = 2'b00;
      be   = 4'b1111;
      case (size)
         SizeB: begin
            lane = addr_lo;
            be   = 4'b0001 << addr_lo;
         end
         SizeH: begin
            lane = {addr_lo[1], 1'b0};
            be   = 4'b0011 << lane;
         end
         default: begin
            lane = 2'b00;
            be   = 4'b1111;
         end
      endcase

      wdata_sh = wdata << {lane, 3'b000};
      shifted  = rword >> {lane, 3'b000};

      case (size)
         SizeB:   rdata_ext = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
         SizeH:   rdata_ext = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
         default: rdata_ext = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_sized_ctrl.sv
// Sized data memory with ready/valid request handshake and pulsed response.
// Byte/half/word loads (signed or unsigned) and stores, range fault, configurable load latency.
// One request in flight; stores and RD_LAT==1 loads sustain one request per cycle.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req_valid / req_ready   request handshake (accept = both high at posedge)
//   req_we, req_size        store flag, access size
//   req_unsigned            load extension select
//   req_addr, req_wdata     byte address, right-justified store data
//   rsp_valid               one-cycle response pulse
//   rsp_rdata, rsp_fault    response data/fault, held between responses
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses;
// otherwise misaligned low address bits are ignored.
module dmem_sized_ctrl
   import dmem_sized_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int unsigned RD_LAT      = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault
);

   localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
   // WAIT spans RD_LAT-1 cycles; the counter reaches 0 in the last of them.
   localparam logic [1:0]  WaitInit = 2'(RD_LAT - 2);

   dmem_state_e state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] pend_data_q, pend_data_d;
   logic        pend_fault_q, pend_fault_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_fault_q, rsp_fault_d;

   logic [31:0] mem [DEPTH_WORDS];

   mem_size_e   size;
   logic [31:0] offset;
   logic [IdxW-1:0] idx;
   logic        in_range;
   logic        misalign;
   logic        fault;
   logic        accept;
   logic        do_write;
   logic [3:0]  be;
   logic [31:0] wdata_sh;
   logic [31:0] ld_data;
   logic [31:0] acc_data;

   assign size     = mem_size_e'(req_size);
   assign offset   = req_addr - BASE_ADDR;
   assign idx      = offset[IdxW+1:2];
   // Addresses below the base wrap to a large offset and fail this check too.
   assign in_range = (offset >> (IdxW + 2)) == 32'd0;

`ifdef DMEM_MISALIGN_TRAP_EN
   always_comb begin
      case (size)
         SizeB:   misalign = 1'b0;
         SizeH:   misalign = req_addr[0];
         default: misalign = |req_addr[1:0];
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   assign fault     = ~in_range | misalign;
   assign req_ready = (state_q != StWait);
   assign accept    = req_valid & req_ready;
   assign do_write  = accept & req_we & ~fault;
   assign acc_data  = (req_we | fault) ? 32'h0 : ld_data;

   dmem_sized_ctrl_lane_align u_lane_align (
      .size        (size),
      .addr_lo     (req_addr[1:0]),
      .wdata       (req_wdata),
      .rword       (mem[idx]),
      .is_unsigned (req_unsigned),
      .be          (be),
      .wdata_sh    (wdata_sh),
      .rdata_ext   (ld_data)
   );

   // Array contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pend_data_d  = pend_data_q;
      pend_fault_d = pend_fault_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_fault_d  = rsp_fault_q;
      case (state_q)
         StWait: begin
            if (cnt_q == 2'd0) begin
               state_d     = StResp;
               rsp_rdata_d = pend_data_q;
               rsp_fault_d = pend_fault_q;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: begin
            state_d = StIdle;
            if (accept) begin
               // Loads were read at accept; longer latencies just park the result.
               if (req_we || RD_LAT == 1) begin
                  state_d     = StResp;
                  rsp_rdata_d = acc_data;
                  rsp_fault_d = fault;
               end else begin
                  state_d      = StWait;
                  cnt_d        = WaitInit;
                  pend_data_d  = acc_data;
                  pend_fault_d = fault;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= 2'd0;
         pend_data_q  <= 32'h0;
         pend_fault_q <= 1'b0;
         rsp_rdata_q  <= 32'h0;
         rsp_fault_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pend_data_q  <= pend_data_d;
         pend_fault_q <= pend_fault_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_fault_q  <= rsp_fault_d;
      end
   end

   assign rsp_valid = (state_q == StResp);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_dmem_sized_ctrl.sv
// Self-checking bench for dmem_sized_ctrl: byte-array reference model, expectation queue,
// directed cases followed by randomized traffic.
module tb_dmem_sized_ctrl;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned LAT   = 3;
   localparam logic [31:0] BASE  = 32'h0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;

   always #5 clk = ~clk;

   dmem_sized_ctrl #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE),
      .RD_LAT      (LAT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_fault    (rsp_fault)
   );

   typedef struct {
      logic [31:0] data;
      logic        fault;
      int unsigned due;
   } exp_t;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;
   int unsigned ready_at = 0;
   logic [7:0]  mem_m [4*DEPTH];
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [32:0] last_rsp = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Reference: memory as bytes, accesses as byte runs of 1/2/4 at a size-aligned start.
   function automatic void model_op(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    output logic [31:0] data, output logic fault);
      int unsigned nb;
      logic [31:0] off;
      logic [31:0] start;
      logic [31:0] val;
      nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      off   = addr - BASE;
      fault = (off >= 4 * DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
      if ((off % nb) != 0) fault = 1'b1;
`endif
      data = 32'h0;
      if (fault) return;
      start = off - (off % nb);
      if (we) begin
         for (int i = 0; i < nb; i++) mem_m[start + i] = wdata[8*i +: 8];
      end else begin
         val = 32'h0;
         for (int i = 0; i < nb; i++) val = val | (32'(mem_m[start + i]) << (8 * i));
         if (!uns && nb < 4 && val[8*nb-1]) val = val | ~((32'd1 << (8 * nb)) - 32'd1);
         data = val;
      end
   endfunction

   // Present one request from posedge+1; returns at posedge+1 after it is accepted.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic use_exp, input logic [31:0] exp_data, input logic exp_fault);
      logic [31:0] md;
      logic        mf;
      exp_t        e;
      bit          done;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      done         = 0;
      for (int t = 0; t < 8 && !done; t++) begin
         check_eq("req_ready", 64'(req_ready), 64'(cyc >= ready_at));
         if (req_ready) begin
            model_op(we, size, uns, addr, wdata, md, mf);
            e.data  = use_exp ? exp_data : md;
            e.fault = use_exp ? exp_fault : mf;
            e.due   = cyc + (we ? 1 : LAT);
            if (!we) ready_at = cyc + LAT;
            exp_q.push_back(e);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      if (!done) check_eq("accept_timeout", 64'(0), 64'(1));
   endtask

   task automatic idle(input int unsigned n);
      req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_rsp", 64'(rsp_valid), 64'(0));
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("rsp_latency", 64'(cyc), 64'(mon_e.due));
               check_eq("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.data));
               check_eq("rsp_fault", 64'(rsp_fault), 64'(mon_e.fault));
            end
            last_rsp = {rsp_fault, rsp_rdata};
         end else begin
            check_eq("rsp_hold", 64'({rsp_fault, rsp_rdata}), 64'(last_rsp));
         end
      end
   end

   initial begin
      #2;
      check_eq("reset_ready", 64'(req_ready), 64'(1));
      check_eq("reset_valid", 64'(rsp_valid), 64'(0));
      check_eq("reset_rdata", 64'(rsp_rdata), 64'(0));
      check_eq("reset_fault", 64'(rsp_fault), 64'(0));
      #10 reset = 1'b0;
      @(posedge clk);
      #1;

      // Give every word a known value.
      for (int i = 0; i < DEPTH; i++) issue(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, 1'b0, 32'h0, 1'b0);

      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
      issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h80, 1'b0, 32'h0, 1'b0);
      issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0);
      issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 32'h00000080, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0);
      issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, 1'b0, 32'h0, 1'b0);
      issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h8001, 1'b0, 32'h0, 1'b0);
      issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b1, 32'hFFFF8001, 1'b0);
      issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b1, 32'h00008001, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 32'h80015678, 1'b0);
      issue(1'b1, 2'd2, 1'b0, 32'h0, 32'h0BADF00D, 1'b0, 32'h0, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h0, 1'b1, 32'h0, 1'b1);
      issue(1'b1, 2'd2, 1'b0, 32'(4 * DEPTH), 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
      issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0BADF00D, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
      issue(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, 1'b1);
`else
      issue(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0);
`endif

      // Reset while a load sits in WAIT: it must vanish without a response.
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0);
      #3;
      reset = 1'b1;
      exp_q.delete();
      ready_at = 0;
      last_rsp = '0;
      #1;
      check_eq("rst_wait_ready", 64'(req_ready), 64'(1));
      check_eq("rst_wait_valid", 64'(rsp_valid), 64'(0));
      check_eq("rst_wait_rdata", 64'(rsp_rdata), 64'(0));
      repeat (2) @(posedge clk);
      #4 reset = 1'b0;
      @(posedge clk);
      #1;
      check_eq("post_rst_ready", 64'(req_ready), 64'(1));
      idle(LAT + 2);

      // Back-to-back stream; stores must never see req_ready drop.
      issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
      issue(1'b1, 2'd2, 1'b0, 32'h44, 32'h01234567, 1'b0, 32'h0, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 1'b1, 32'h01234567, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);

      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         if ($urandom_range(0, 9) == 0) begin
            a = ($urandom_range(0, 1) == 0) ? 32'(4 * DEPTH + $urandom_range(0, 255))
                                             : 32'hFFFFFF00 + 32'($urandom_range(0, 255));
         end else begin
            a = 32'($urandom_range(0, 4 * DEPTH - 1));
         end
         issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               a, $urandom, 1'b0, 32'h0, 1'b0);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end

      idle(1);
      for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
      #1;
      check_eq("drain", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
